idwt_haar_non_pipelined: RTL
============================

Name: idwt_haar_non_pipelined

Overview:
Inverse single-level Haar DWT reconstructor. It takes N/2 approximation (cA) and N/2 detail (cD) coefficients, as produced by the team's forward Haar DWT, and rebuilds N samples pair by pair. Sample pairs are produced sequentially through one shared arithmetic core, using a start/done handshake. It sits downstream of coefficient processing and mirrors the forward block's ×181/256 (≈1/√2) fixed-point scaling.

Parameters:
N, 8, number of reconstructed samples. Must be even and ≥2; N/2 must be a power of two.

Ports:
clk  input  1  clock, all state updates on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request reconstruction; sampled only in IDLE
cA_in  input  16*(N/2)  approximation coefficients; cA_i = cA_in[i*16 +: 16], signed two's complement
cD_in  input  16*(N/2)  detail coefficients; cD_i = cD_in[i*16 +: 16], signed two's complement
array_out  output  16*N  reconstructed samples; x0_i at [(2i)*16 +: 16], x1_i at [(2i+1)*16 +: 16]
busy  output  1  high in LOAD/PROCESS/STORE
done  output  1  high while in DONE

Behaviour:
- Reset (synchronous, rst=1 at a rising edge): state=IDLE, pair index=0, array_out=0, busy=0, done=0, snapshot and pipeline registers=0. Reset has priority over everything, including mid-operation; any partial results are discarded.
- Arithmetic, per pair i, all in 32-bit wrap-around:
  - A = sext32(cA_i)*181; D = sext32(cD_i)*181.
  - x0_i = (A + D)[23:8]; x1_i = (A − D)[23:8].
  - Subtraction is done as A + ~D + 1. Multiplication by 181 is the shift-add (<<7)+(<<5)+(<<4)+(<<2)+(<<0). Any adder implementation is allowed if it is bit-exact.
- FSM states: IDLE, LOAD, PROCESS, STORE, DONE.
  - IDLE: if start=1, snapshot cA_in/cD_in into internal registers, clear array_out to 0, set pair index=0, go to LOAD. Input buses may change freely after the accepting edge.
  - LOAD: register cA_i and cD_i from the snapshot. Go to PROCESS.
  - PROCESS: register x0_i and x1_i from the core. Go to STORE.
  - STORE: write x0_i and x1_i into array_out at pair i. If i == N/2−1 go to DONE; otherwise increment i and go to LOAD.
  - DONE: done=1. Stay while start=1; return to IDLE when start=0. A new start is only accepted after passing through IDLE.
- Latency: with start accepted at edge 0, pair i becomes valid in array_out after edge 3i+3. done rises after edge 3*(N/2), which is 12 for N=8, in the same cycle the last pair becomes valid.
- busy and done are registered decodes of state. They are never high at the same time.
- start is ignored while busy and while in DONE.
- array_out holds its value through DONE and IDLE until the next accepted start or rst.
- No overflow flag exists. Out-of-range results wrap, keeping bits [23:8] only (see Optional Feature).

Optional Feature:
IDWT_SAT_EN
- Defined: each 32-bit sum or difference S is saturated before output.
  - If S >>> 8 (arithmetic shift) > 32767, output 16'h7FFF.
  - If S >>> 8 < −32768, output 16'h8000.
  - Otherwise output S[23:8].
  - Adds one comparison stage inside PROCESS; cycle latency is unchanged.
- Undefined: plain truncation to S[23:8] (wrap).

Test Plan:
- Reset then idle, N=8: assert rst for 2 cycles → array_out=0, busy=0, done=0; start held low for 20 cycles → state stays IDLE.
- DC pair: cA_0=16'h0100, cD_0=0, all other pairs 0, pulse start → x0_0 = x1_0 = 16'h00B5; other samples 0; done rises exactly 12 edges after start accepted.
- Signed detail: cA_1=0, cD_1=16'hFF00 → x0_1=16'hFF4B, x1_1=16'h00B5. Also cA_2 = cD_2 = 16'h0100 → x0_2=16'h016A, x1_2=16'h0000.
- Overflow: cA_3 = cD_3 = 16'h7FFF → x0_3=16'hB4FE without IDWT_SAT_EN and 16'h7FFF with it; x1_3=16'h0000 in both builds.
- Handshake: hold start high through DONE → done stays 1 and no restart occurs. Change cA_in mid-run → outputs reflect the snapshot taken at acceptance. Drop start → IDLE next edge; re-raise start → new run begins and array_out clears to 0.
- Reset mid-run: assert rst during PROCESS of pair 2 → next cycle array_out=0, busy=0, done=0, state IDLE; a following start produces a complete, correct run.

Source files
------------

// File: rtl/idwt_haar_non_pipelined.sv
// Inverse single-level Haar DWT: rebuilds N samples from N/2 cA/cD pairs, one pair per 3 cycles.
// Optional IDWT_SAT_EN macro clamps each result to the 16-bit range instead of wrapping.
module idwt_haar_non_pipelined #(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [16*(N/2)-1:0]   cA_in,
  input  logic [16*(N/2)-1:0]   cD_in,
  output logic [16*N-1:0]       array_out,
  output logic                  busy,
  output logic                  done
);
  localparam int P  = N / 2;
  localparam int IW = (P > 1) ? $clog2(P) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, PROCESS, STORE, DONE} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [16*P-1:0]   ca_snap_q, cd_snap_q;
  logic [15:0]       ca_q, cd_q, x0_q, x1_q;
  logic [16*N-1:0]   out_q;
  logic              busy_q, done_q;
  logic [31:0]       a_w, d_w, sum_w, dif_w;

  // x181 as shift-add on the sign-extended coefficient (~1/sqrt2 after >>8)
  function automatic logic [31:0] mul181(input logic [15:0] v);
    logic [31:0] s;
    s = {{16{v[15]}}, v};
    return (s << 7) + (s << 5) + (s << 4) + (s << 2) + s;
  endfunction

  function automatic logic [15:0] fit(input logic [31:0] s);
`ifdef IDWT_SAT_EN
    if (!s[31] && (s[30:23] != 8'h00))      return 16'h7FFF;
    else if (s[31] && (s[30:23] != 8'hFF))  return 16'h8000;
    else                                    return s[23:8];
`else
    return s[23:8];
`endif
  endfunction

  assign a_w   = mul181(ca_q);
  assign d_w   = mul181(cd_q);
  assign sum_w = a_w + d_w;
  assign dif_w = a_w + ~d_w + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= (state_d == LOAD) || (state_d == PROCESS) || (state_d == STORE);
      done_q  <= (state_d == DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        idx_d   = '0;
      end
      LOAD:    state_d = PROCESS;
      PROCESS: state_d = STORE;
      STORE: begin
        if (idx_q == IW'(P - 1)) state_d = DONE;
        else begin
          state_d = LOAD;
          idx_d   = idx_q + 1'b1;
        end
      end
      DONE:    if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ca_snap_q <= '0;
      cd_snap_q <= '0;
      ca_q      <= '0;
      cd_q      <= '0;
      x0_q      <= '0;
      x1_q      <= '0;
      out_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          ca_snap_q <= cA_in;
          cd_snap_q <= cD_in;
          out_q     <= '0;
        end
        LOAD: begin
          ca_q <= ca_snap_q[int'(idx_q)*16 +: 16];
          cd_q <= cd_snap_q[int'(idx_q)*16 +: 16];
        end
        PROCESS: begin
          x0_q <= fit(sum_w);
          x1_q <= fit(dif_w);
        end
        STORE:   out_q[int'(idx_q)*32 +: 32] <= {x1_q, x0_q};
        default: ;
      endcase
    end
  end

  assign array_out = out_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule
